// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush sequencing (load-use, memory wait, branch, jump); optional perf counters under `HAZ_PERF_EN
module hazard_stall_ctrl #(
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_br_taken,
  input  logic        id_jump,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        err_clr,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_freeze,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);
  typedef enum logic [1:0] {RUN = 2'b00, LU_STALL = 2'b01, MEM_WAIT = 2'b10, ILLEGAL = 2'b11} state_t;
  state_t state, state_nx, ret, ret_nx;
  logic [1:0] bub, bub_nx;
  logic [7:0] tmo, tmo_nx;
  logic mem_hit, lu_hit, timeout;
  assign mem_hit = mem_req & ~mem_ready;
  assign lu_hit  = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign timeout = (state == MEM_WAIT) & ~mem_ready & (tmo == 8'(MEM_TIMEOUT));
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    state_nx    = RUN;
    ret_nx      = ret;
    bub_nx      = bub;
    tmo_nx      = tmo;
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (state == MEM_WAIT) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
      tmo_nx      = tmo + 8'd1;
      state_nx    = mem_ready ? ret : timeout ? RUN : MEM_WAIT;
    end else if (mem_hit) begin
      // remember whether a load-use sequence was interrupted so it resumes afterwards
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
      tmo_nx      = 8'd1;
      state_nx    = MEM_WAIT;
      ret_nx      = (state == LU_STALL) ? LU_STALL : RUN;
    end else if (ex_br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end else if (state == LU_STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      bub_nx      = bub - 2'd1;
      state_nx    = (bub == 2'd1) ? RUN : LU_STALL;
    end else if (lu_hit) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (LOAD_BUBBLES > 1) begin
        state_nx = LU_STALL;
        bub_nx   = 2'(LOAD_BUBBLES - 1);
      end
    end
    // the illegal encoding behaves as RUN for outputs but always recovers to RUN
    if (state == ILLEGAL) state_nx = RUN;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      ret     <= RUN;
      bub     <= 2'd0;
      tmo     <= 8'd0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nx;
      ret     <= ret_nx;
      bub     <= bub_nx;
      tmo     <= tmo_nx;
      mem_err <= timeout ? 1'b1 : err_clr ? 1'b0 : mem_err;
    end
  end
`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= 32'h0;
      flush_count  <= 32'h0;
    end else begin
      if (!pc_write) stall_cycles <= stall_cycles + 32'h1;
      if (ifid_flush) flush_count <= flush_count + 32'h1;
    end
  end
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks of two configurations (1 bubble/255 timeout and 2 bubbles/4 timeout)
module tb_hazard_stall_ctrl;
`ifdef HAZ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  // {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_freeze, mem_err}
  localparam logic [6:0] DEF = 7'b1100000;
  localparam logic [6:0] STL = 7'b0010000;
  localparam logic [6:0] BRF = 7'b1101100;
  localparam logic [6:0] JMP = 7'b1101000;
  localparam logic [6:0] FRZ = 7'b0000010;
  localparam logic [6:0] ERR = 7'b1100001;
  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_memread, ex_br_taken, id_jump, mem_req, mem_ready, err_clr;
  logic pc_write1, ifid_write1, idex_bubble1, ifid_flush1, idex_flush1, pipe_freeze1, mem_err1;
  logic pc_write2, ifid_write2, idex_bubble2, ifid_flush2, idex_flush2, pipe_freeze2, mem_err2;
  logic [31:0] stall_cycles1, flush_count1, stall_cycles2, flush_count2;
  int tests = 0, fails = 0;
  int es1 = 0, ef1 = 0, es2 = 0, ef2 = 0;
  always #5 clk = ~clk;
  hazard_stall_ctrl u_dut1 (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken), .id_jump(id_jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .err_clr(err_clr),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .idex_bubble(idex_bubble1),
    .ifid_flush(ifid_flush1), .idex_flush(idex_flush1), .pipe_freeze(pipe_freeze1),
    .mem_err(mem_err1), .stall_cycles(stall_cycles1), .flush_count(flush_count1));
  hazard_stall_ctrl #(.LOAD_BUBBLES(2), .MEM_TIMEOUT(4)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken), .id_jump(id_jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .err_clr(err_clr),
    .pc_write(pc_write2), .ifid_write(ifid_write2), .idex_bubble(idex_bubble2),
    .ifid_flush(ifid_flush2), .idex_flush(idex_flush2), .pipe_freeze(pipe_freeze2),
    .mem_err(mem_err2), .stall_cycles(stall_cycles2), .flush_count(flush_count2));
  wire [6:0] o1 = {pc_write1, ifid_write1, idex_bubble1, ifid_flush1, idex_flush1, pipe_freeze1, mem_err1};
  wire [6:0] o2 = {pc_write2, ifid_write2, idex_bubble2, ifid_flush2, idex_flush2, pipe_freeze2, mem_err2};
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0;
    ex_br_taken = 1'b0; id_jump = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; err_clr = 1'b0;
  endtask
  task automatic lu(input logic [4:0] r);
    ex_memread = 1'b1; ex_rt = r; id_rs = r;
  endtask
  task automatic vec(input string tag, input logic [6:0] e1, input logic [6:0] e2);
    #1;
    chk({tag, ".o1"}, 32'(o1), 32'(e1));
    chk({tag, ".o2"}, 32'(o2), 32'(e2));
    chk({tag, ".st1"}, stall_cycles1, PERF ? 32'(es1) : 32'h0);
    chk({tag, ".fl1"}, flush_count1, PERF ? 32'(ef1) : 32'h0);
    chk({tag, ".st2"}, stall_cycles2, PERF ? 32'(es2) : 32'h0);
    chk({tag, ".fl2"}, flush_count2, PERF ? 32'(ef2) : 32'h0);
    if (!e1[6]) es1++;
    if (e1[3]) ef1++;
    if (!e2[6]) es2++;
    if (e2[3]) ef2++;
    @(posedge clk);
    #1;
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, ".o1"}, 32'(o1), 32'(STL));
    chk({tag, ".o2"}, 32'(o2), 32'(STL));
    chk({tag, ".st1"}, stall_cycles1, 32'h0);
    chk({tag, ".fl1"}, flush_count1, 32'h0);
    chk({tag, ".st2"}, stall_cycles2, 32'h0);
    chk({tag, ".fl2"}, flush_count2, 32'h0);
  endtask
  initial begin
    idle();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 rst_chk("rst0");
    repeat (2) @(posedge clk);
    #1 rst_chk("rst1");
    reset_n = 1'b1;
    vec("run", DEF, DEF);
    // load-use: dut1 one bubble, dut2 two
    lu(5'd2);
    vec("lu_a1", STL, STL);
    idle();
    vec("lu_a2", DEF, STL);
    vec("lu_a3", DEF, DEF);
    // ex_rt zero never hazards
    ex_memread = 1'b1;
    vec("lu_zero", DEF, DEF);
    // rt match only counts when the ID instruction reads rt
    ex_memread = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd1;
    vec("lu_rt_unused", DEF, DEF);
    id_uses_rt = 1'b1;
    vec("lu_rt1", STL, STL);
    idle();
    vec("lu_rt2", DEF, STL);
    vec("lu_rt3", DEF, DEF);
    // branch outranks load-use
    lu(5'd3); ex_br_taken = 1'b1;
    vec("br_lu", BRF, BRF);
    idle();
    vec("br_after", DEF, DEF);
    // branch cancels an in-progress LU_STALL
    lu(5'd6);
    vec("br_ls1", STL, STL);
    idle(); ex_br_taken = 1'b1;
    vec("br_ls2", BRF, BRF);
    idle();
    vec("br_ls3", DEF, DEF);
    // jump outranks load-use
    lu(5'd7); id_jump = 1'b1;
    vec("jmp_lu", JMP, JMP);
    idle();
    vec("jmp_after", DEF, DEF);
    // memory wait: ready low three cycles, then ready
    mem_req = 1'b1;
    vec("mw1", FRZ, FRZ);
    vec("mw2", FRZ, FRZ);
    vec("mw3", FRZ, FRZ);
    mem_ready = 1'b1;
    vec("mw4", FRZ, FRZ);
    idle();
    vec("mw_done", DEF, DEF);
    // timeout on dut2 after four MEM_WAIT cycles; set beats clear
    mem_req = 1'b1;
    vec("to1", FRZ, FRZ);
    vec("to2", FRZ, FRZ);
    vec("to3", FRZ, FRZ);
    vec("to4", FRZ, FRZ);
    err_clr = 1'b1;
    vec("to5", FRZ, FRZ);
    idle();
    vec("to6", FRZ, ERR);
    mem_ready = 1'b1;
    vec("to7", FRZ, ERR);
    idle(); err_clr = 1'b1;
    vec("clr1", DEF, ERR);
    idle();
    vec("clr2", DEF, DEF);
    // memory wait interrupting LU_STALL resumes the remaining bubble
    lu(5'd4);
    vec("ls_mw1", STL, STL);
    idle(); mem_req = 1'b1;
    vec("ls_mw2", FRZ, FRZ);
    mem_ready = 1'b1;
    vec("ls_mw3", FRZ, FRZ);
    idle();
    vec("ls_mw4", DEF, STL);
    vec("ls_mw5", DEF, DEF);
    // asynchronous reset during MEM_WAIT
    mem_req = 1'b1;
    vec("rw1", FRZ, FRZ);
    vec("rw2", FRZ, FRZ);
    reset_n = 1'b0;
    #1 rst_chk("rw_rst");
    es1 = 0; ef1 = 0; es2 = 0; ef2 = 0;
    idle();
    @(posedge clk);
    #1 reset_n = 1'b1;
    vec("rw_run", DEF, DEF);
    lu(5'd9);
    vec("rw_lu", STL, STL);
    idle();
    vec("rw_end", DEF, STL);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
